// File: rtl/jk_universal_register_if.sv
// ---------------------------------------------------------------------------
// jk_universal_register_if
// Bus bundle for jk_universal_register. The master drives the control and
// data inputs. The slave (the register) drives the state and the flags.
//   en      : update enable
//   mode    : 00 per-bit JK, 01 load, 10 up/down count, 11 shift
//   j, k    : per-bit JK inputs (mode 00)
//   d       : parallel load data (mode 01)
//   dir     : count up / shift left when 1
//   ser_in  : serial input (mode 11)
//   q       : registered state
//   ser_out : serial output bit
//   tc      : terminal count flag
//   q_chg   : one-cycle pulse after q changed
// ---------------------------------------------------------------------------
interface jk_universal_register_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic [1:0]       mode;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic [WIDTH-1:0] d;
  logic             dir;
  logic             ser_in;
  logic [WIDTH-1:0] q;
  logic             ser_out;
  logic             tc;
  logic             q_chg;

  modport master (
    output en, mode, j, k, d, dir, ser_in,
    input  q, ser_out, tc, q_chg
  );

  modport slave (
    input  en, mode, j, k, d, dir, ser_in,
    output q, ser_out, tc, q_chg
  );
endinterface

// File: rtl/jk_universal_register.sv
// ---------------------------------------------------------------------------
// jk_universal_register
// Universal WIDTH-bit register. It does per-bit JK, parallel load, up/down
// counting built from JK toggles, and left/right serial shift.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous, active-low reset (q <= RST_VAL, q_chg <= 0)
//   bus : jk_universal_register_if slave modport (see interface header)
// ---------------------------------------------------------------------------
module jk_universal_register #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  jk_universal_register_if.slave   bus
);

  localparam logic [1:0] MODE_JK    = 2'b00;
  localparam logic [1:0] MODE_LOAD  = 2'b01;
  localparam logic [1:0] MODE_COUNT = 2'b10;
  localparam logic [1:0] MODE_SHIFT = 2'b11;

  logic [WIDTH-1:0] r_q;
  logic             r_q_chg;
  logic [WIDTH-1:0] w_tog;
  logic [WIDTH-1:0] w_q_next;
  logic             w_run;

  // The counter is a JK ripple-free synchronous counter. Bit i toggles when
  // every lower bit is 1 (up) or every lower bit is 0 (down). w_run carries
  // that "all lower bits match" condition upward through the word.
  always_comb begin
    w_tog = '0;
    w_run = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      w_tog[i] = w_run;
      w_run    = w_run & (bus.dir ? r_q[i] : ~r_q[i]);
    end
  end

  always_comb begin
    w_q_next = r_q;
    if (bus.en) begin
      unique case (bus.mode)
        // {j,k}: 00 hold, 01 clear, 10 set, 11 toggle
        MODE_JK:    w_q_next = (bus.j & ~r_q) | (~bus.k & r_q);
        MODE_LOAD:  w_q_next = bus.d;
        MODE_COUNT: w_q_next = r_q ^ w_tog;
        MODE_SHIFT: w_q_next = bus.dir ? {r_q[WIDTH-2:0], bus.ser_in}
                                       : {bus.ser_in, r_q[WIDTH-1:1]};
        default:    w_q_next = r_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_q     <= RST_VAL;
      r_q_chg <= 1'b0;
    end else begin
      r_q     <= w_q_next;
      r_q_chg <= (w_q_next != r_q);
    end
  end

  assign bus.q       = r_q;
  assign bus.q_chg   = r_q_chg;
  assign bus.ser_out = bus.dir ? r_q[WIDTH-1] : r_q[0];
  assign bus.tc      = bus.en && (bus.mode == MODE_COUNT) &&
                       (bus.dir ? (&r_q) : ~(|r_q));

endmodule
